// File: rtl/fft8_out_serializer.sv
// fft8_out_serializer: buffers parallel fft8 result frames and replays them one complex sample per cycle with valid/ready
// in : clk, rstn (sync, active low), yout_valid, y0..y7_real/imag, out_ready
// out: out_valid, out_real, out_imag, out_index, out_last, overflow (sticky drop flag), frame_count (accepted frames mod 256)
module fft8_out_serializer #(
  parameter int DW = 24,
  parameter int DEPTH = 2,
  parameter int BITREV = 0
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          yout_valid,
  input  logic [DW-1:0] y0_real,
  input  logic [DW-1:0] y0_imag,
  input  logic [DW-1:0] y1_real,
  input  logic [DW-1:0] y1_imag,
  input  logic [DW-1:0] y2_real,
  input  logic [DW-1:0] y2_imag,
  input  logic [DW-1:0] y3_real,
  input  logic [DW-1:0] y3_imag,
  input  logic [DW-1:0] y4_real,
  input  logic [DW-1:0] y4_imag,
  input  logic [DW-1:0] y5_real,
  input  logic [DW-1:0] y5_imag,
  input  logic [DW-1:0] y6_real,
  input  logic [DW-1:0] y6_imag,
  input  logic [DW-1:0] y7_real,
  input  logic [DW-1:0] y7_imag,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_real,
  output logic [DW-1:0] out_imag,
  output logic [2:0]    out_index,
  output logic          out_last,
  output logic          overflow,
  output logic [7:0]    frame_count
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  typedef enum logic {IDLE, STREAM} state_t;
  state_t state;
  logic [DW-1:0] yr [8];
  logic [DW-1:0] yi [8];
  logic [DW-1:0] mre [DEPTH][8];
  logic [DW-1:0] mim [DEPTH][8];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [2:0] s, idx;
  logic xfer, rel, accept;
  assign yr = '{y0_real, y1_real, y2_real, y3_real, y4_real, y5_real, y6_real, y7_real};
  assign yi = '{y0_imag, y1_imag, y2_imag, y3_imag, y4_imag, y5_imag, y6_imag, y7_imag};
  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  assign idx = (BITREV != 0) ? {s[0], s[1], s[2]} : s;
  assign out_valid = (state == STREAM);
  assign xfer = out_valid & out_ready;
  assign rel = xfer & (s == 3'd7);
  // a full buffer can still take a frame on the edge its head frame's last sample leaves
  assign accept = yout_valid & ((count < CW'(DEPTH)) | rel);
  assign out_index = out_valid ? idx : 3'd0;
  assign out_real = out_valid ? mre[rd_ptr][idx] : '0;
  assign out_imag = out_valid ? mim[rd_ptr][idx] : '0;
  assign out_last = out_valid & (s == 3'd7);
  always_ff @(posedge clk)
    if (accept)
      for (int k = 0; k < 8; k++) begin
        mre[wr_ptr][k] <= yr[k];
        mim[wr_ptr][k] <= yi[k];
      end
  always_ff @(posedge clk)
    if (!rstn) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      s <= '0;
      overflow <= 1'b0;
      frame_count <= '0;
    end else begin
      if (accept) wr_ptr <= inc(wr_ptr);
      if (accept) frame_count <= frame_count + 8'd1;
      if (yout_valid && !accept) overflow <= 1'b1;
      if (xfer) s <= s + 3'd1;
      if (rel) rd_ptr <= inc(rd_ptr);
      count <= count + CW'(accept) - CW'(rel);
      state <= (state == IDLE) ? (accept ? STREAM : IDLE)
                               : ((rel && count == CW'(1) && !accept) ? IDLE : STREAM);
    end
endmodule

// File: tb/tb_fft8_out_serializer.sv
// tb_fft8_out_serializer: checks in-order and bit-reversed serializer instances against a frame-queue model
module tb_fft8_out_serializer;
  localparam int DW = 24;
  localparam int DEPTH = 2;
  typedef struct packed {
    logic [7:0][DW-1:0] re;
    logic [7:0][DW-1:0] im;
  } frame_t;
  logic clk = 0, rstn = 0, yout_valid = 0, out_ready = 0;
  frame_t cur = '0;
  logic v0, v1, l0, l1, o0, o1;
  logic [DW-1:0] r0, r1, i0, i1;
  logic [2:0] x0, x1;
  logic [7:0] f0, f1;
  int n_assert = 0, n_fail = 0;
  frame_t q[$];
  int sent = 0;
  logic ovf = 0;
  logic [7:0] fc = 0;
  int br[8] = '{0, 4, 2, 6, 1, 5, 3, 7};
  always #5 clk = ~clk;
  fft8_out_serializer #(.DW(DW), .DEPTH(DEPTH), .BITREV(0)) dut0 (
    .clk(clk), .rstn(rstn), .yout_valid(yout_valid),
    .y0_real(cur.re[0]), .y0_imag(cur.im[0]), .y1_real(cur.re[1]), .y1_imag(cur.im[1]),
    .y2_real(cur.re[2]), .y2_imag(cur.im[2]), .y3_real(cur.re[3]), .y3_imag(cur.im[3]),
    .y4_real(cur.re[4]), .y4_imag(cur.im[4]), .y5_real(cur.re[5]), .y5_imag(cur.im[5]),
    .y6_real(cur.re[6]), .y6_imag(cur.im[6]), .y7_real(cur.re[7]), .y7_imag(cur.im[7]),
    .out_ready(out_ready), .out_valid(v0), .out_real(r0), .out_imag(i0),
    .out_index(x0), .out_last(l0), .overflow(o0), .frame_count(f0));
  fft8_out_serializer #(.DW(DW), .DEPTH(DEPTH), .BITREV(1)) dut1 (
    .clk(clk), .rstn(rstn), .yout_valid(yout_valid),
    .y0_real(cur.re[0]), .y0_imag(cur.im[0]), .y1_real(cur.re[1]), .y1_imag(cur.im[1]),
    .y2_real(cur.re[2]), .y2_imag(cur.im[2]), .y3_real(cur.re[3]), .y3_imag(cur.im[3]),
    .y4_real(cur.re[4]), .y4_imag(cur.im[4]), .y5_real(cur.re[5]), .y5_imag(cur.im[5]),
    .y6_real(cur.re[6]), .y6_imag(cur.im[6]), .y7_real(cur.re[7]), .y7_imag(cur.im[7]),
    .out_ready(out_ready), .out_valid(v1), .out_real(r1), .out_imag(i1),
    .out_index(x1), .out_last(l1), .overflow(o1), .frame_count(f1));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s at %0t: observed %0h expected %0h", tag, $time, obs, exp);
    end
  endtask
  task automatic check(input string p, input int bitrev, input logic v, input logic l, input logic o,
                       input logic [DW-1:0] r, input logic [DW-1:0] i, input logic [2:0] x, input logic [7:0] f);
    logic e;
    int k;
    e = q.size() > 0;
    k = e ? (bitrev != 0 ? br[sent] : sent) : 0;
    chk({p, ".valid"}, 32'(v), 32'(e));
    chk({p, ".real"}, 32'(r), e ? 32'(q[0].re[k]) : 32'd0);
    chk({p, ".imag"}, 32'(i), e ? 32'(q[0].im[k]) : 32'd0);
    chk({p, ".index"}, 32'(x), 32'(k));
    chk({p, ".last"}, 32'(l), 32'(e && sent == 7));
    chk({p, ".overflow"}, 32'(o), 32'(ovf));
    chk({p, ".frame_count"}, 32'(f), 32'(fc));
  endtask
  task automatic step();
    logic rel, xf;
    check("inorder", 0, v0, l0, o0, r0, i0, x0, f0);
    check("bitrev", 1, v1, l1, o1, r1, i1, x1, f1);
    if (!rstn) begin
      q.delete();
      sent = 0;
      ovf = 0;
      fc = 0;
    end else begin
      rel = q.size() > 0 && out_ready && sent == 7;
      xf = q.size() > 0 && out_ready;
      if (yout_valid) begin
        if (q.size() < DEPTH || rel) begin
          q.push_back(cur);
          fc++;
        end else ovf = 1;
      end
      if (xf) begin
        sent++;
        if (sent == 8) begin
          void'(q.pop_front());
          sent = 0;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask
  function automatic frame_t rnd();
    frame_t f;
    for (int k = 0; k < 8; k++) begin
      f.re[k] = DW'($urandom);
      f.im[k] = DW'($urandom);
    end
    return f;
  endfunction
  function automatic frame_t ramp();
    frame_t f;
    for (int k = 0; k < 8; k++) begin
      f.re[k] = DW'(k + 1);
      f.im[k] = DW'(-(k + 1));
    end
    return f;
  endfunction
  initial begin
    repeat (2) @(posedge clk);
    #1;
    rstn = 1;
    // single ramp frame
    cur = ramp();
    out_ready = 1;
    yout_valid = 1;
    step();
    yout_valid = 0;
    repeat (10) step();
    chk("t1_frame_count", 32'(f0), 32'd1);
    // three back-to-back frames into a two-slot buffer: third is dropped
    for (int n = 0; n < 3; n++) begin
      cur = rnd();
      yout_valid = 1;
      step();
    end
    yout_valid = 0;
    repeat (20) step();
    chk("t2_overflow", 32'(o0), 32'd1);
    chk("t2_frame_count", 32'(f0), 32'd3);
    rstn = 0;
    step();
    rstn = 1;
    // stall at index 3
    cur = ramp();
    yout_valid = 1;
    step();
    yout_valid = 0;
    for (int n = 0; n < 20 && sent != 3; n++) step();
    out_ready = 0;
    repeat (5) step();
    chk("t3_real", 32'(r0), 32'd4);
    chk("t3_index", 32'(x0), 32'd3);
    out_ready = 1;
    repeat (10) step();
    // full buffer, new frame on the head frame's last transfer
    for (int n = 0; n < 2; n++) begin
      cur = rnd();
      yout_valid = 1;
      step();
    end
    yout_valid = 0;
    for (int n = 0; n < 20 && sent != 7; n++) step();
    cur = rnd();
    yout_valid = 1;
    step();
    yout_valid = 0;
    chk("t5_valid", 32'(v0), 32'd1);
    chk("t5_overflow", 32'(o0), 32'd0);
    repeat (20) step();
    // reset mid-stream with a second frame buffered
    for (int n = 0; n < 2; n++) begin
      cur = rnd();
      yout_valid = 1;
      step();
    end
    yout_valid = 0;
    for (int n = 0; n < 20 && sent != 4; n++) step();
    rstn = 0;
    step();
    rstn = 1;
    chk("t6_valid", 32'(v0), 32'd0);
    chk("t6_frame_count", 32'(f0), 32'd0);
    repeat (12) step();
    // random traffic
    for (int n = 0; n < 1500; n++) begin
      cur = rnd();
      yout_valid = $urandom_range(0, 5) == 0;
      out_ready = $urandom_range(0, 3) != 0;
      rstn = $urandom_range(0, 299) != 0;
      step();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
